// File: rtl/array_pingpong_frame_buf.sv
// Double-buffered frame assembler: serial words fill one bank while the other,
// once complete, is presented as a whole unpacked-array frame.
module array_pingpong_frame_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int BASE  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_frame [BASE:BASE+DEPTH-1],
    output logic [1:0]       level
);

    localparam int            IW   = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    logic [WIDTH-1:0] bank0 [BASE:BASE+DEPTH-1];
    logic [WIDTH-1:0] bank1 [BASE:BASE+DEPTH-1];
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wsel;
    logic             rsel;
    logic [IW-1:0]    widx;
    logic             wr;
    logic             rd;
    logic             wr_done;

    assign in_ready  = !full[wsel];
    assign out_valid = full[rsel];
    assign level     = {1'b0, full[0]} + {1'b0, full[1]};

    // A completing write and an ack always touch different flags, so both apply.
    always_comb begin
        wr       = in_valid && in_ready;
        rd       = out_ack && out_valid;
        wr_done  = wr && (widx == LAST);
        full_nxt = full;
        if (wr_done) full_nxt[wsel] = 1'b1;
        if (rd)      full_nxt[rsel] = 1'b0;
    end

    // Per-element select keeps every frame element driven from the read bank.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            out_frame[BASE+i] = rsel ? bank1[BASE+i] : bank0[BASE+i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            wsel <= 1'b0;
            rsel <= 1'b0;
            widx <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank0[BASE+i] <= '0;
                bank1[BASE+i] <= '0;
            end
        end else begin
            full <= full_nxt;
            if (rd) rsel <= ~rsel;
            if (wr) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (widx == IW'(i)) begin
                        if (wsel) bank1[BASE+i] <= in_data;
                        else      bank0[BASE+i] <= in_data;
                    end
                end
                if (widx == LAST) begin
                    wsel <= ~wsel;
                    widx <= '0;
                end else begin
                    widx <= widx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_array_pingpong_frame_buf.sv
// Table-driven bench for array_pingpong_frame_buf; completed frames are queued
// as they are written and compared against out_frame while presented/acked.
module tb_array_pingpong_frame_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ack;
    logic [7:0] out_frame [3:6];
    logic [1:0] level;

    array_pingpong_frame_buf #(.WIDTH(8), .DEPTH(4), .BASE(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ack(out_ack),
        .out_frame(out_frame), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       ack;
        logic       er;
        logic       ev;
        logic [1:0] el;
        string      name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    logic [31:0] cur;
    int          ncur;
    int          checks   = 0;
    int          failures = 0;
    logic        prev_er;
    logic        prev_ev;

    function automatic void add(logic r, logic iv, logic [7:0] d, logic ack,
                                logic er, logic ev, logic [1:0] el, string name);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.ack = ack;
        v.er = er; v.ev = ev; v.el = el; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] frame_now();
        return {out_frame[6], out_frame[5], out_frame[4], out_frame[3]};
    endfunction

    initial begin
        // test 1/2/3: fill two frames, reject a 9th word, ack one
        add(1, 0, 8'h00, 0, 1, 0, 0, "reset");
        add(0, 1, 8'h11, 0, 1, 0, 0, "t1_w1");
        add(0, 1, 8'h22, 0, 1, 0, 0, "t1_w2");
        add(0, 1, 8'h33, 0, 1, 0, 0, "t1_w3");
        add(0, 1, 8'h44, 0, 1, 1, 1, "t1_w4");
        add(0, 1, 8'h55, 0, 1, 1, 1, "t2_w5");
        add(0, 1, 8'h66, 0, 1, 1, 1, "t2_w6");
        add(0, 1, 8'h77, 0, 1, 1, 1, "t2_w7");
        add(0, 1, 8'h88, 0, 0, 1, 2, "t2_w8");
        add(0, 1, 8'h99, 0, 0, 1, 2, "t2_w9_rej");
        add(0, 0, 8'h00, 1, 1, 1, 1, "t3_ack");
        add(0, 0, 8'h00, 0, 1, 1, 1, "t3_hold");
        // test 4: ack coincides with the last write of a frame
        add(0, 1, 8'hc1, 0, 1, 1, 1, "t4_w1");
        add(0, 1, 8'hc2, 0, 1, 1, 1, "t4_w2");
        add(0, 1, 8'hc3, 0, 1, 1, 1, "t4_w3");
        add(0, 1, 8'hc4, 1, 1, 1, 1, "t4_w4_ack");
        add(0, 0, 8'h00, 0, 1, 1, 1, "t4_hold");
        add(0, 0, 8'h00, 1, 1, 0, 0, "t4_ack");
        // test 5: reset mid-frame
        add(0, 1, 8'hd1, 0, 1, 0, 0, "t5_w1");
        add(0, 1, 8'hd2, 0, 1, 0, 0, "t5_w2");
        add(1, 0, 8'h00, 0, 1, 0, 0, "t5_rst");
        add(0, 1, 8'he1, 0, 1, 0, 0, "t5_w3");
        add(0, 1, 8'he2, 0, 1, 0, 0, "t5_w4");
        add(0, 1, 8'he3, 0, 1, 0, 0, "t5_w5");
        add(0, 1, 8'he4, 0, 1, 1, 1, "t5_w6");
        add(0, 0, 8'h00, 0, 1, 1, 1, "t5_hold");
        // test 6: stray ack while empty must not flip the read pointer
        add(1, 0, 8'h00, 0, 1, 0, 0, "t6_rst");
        add(0, 0, 8'h00, 1, 1, 0, 0, "t6_stray_ack");
        add(0, 1, 8'hf1, 0, 1, 0, 0, "t6_w1");
        add(0, 1, 8'hf2, 0, 1, 0, 0, "t6_w2");
        add(0, 1, 8'hf3, 0, 1, 0, 0, "t6_w3");
        add(0, 1, 8'hf4, 0, 1, 1, 1, "t6_w4");
        add(0, 0, 8'h00, 0, 1, 1, 1, "t6_hold");
        add(0, 0, 8'h00, 1, 1, 0, 0, "t6_ack");

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ack = 1'b0;
        cur = '0; ncur = 0; prev_er = 1'b1; prev_ev = 1'b0;

        for (int unsigned k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst = vecs[k].rst; in_valid = vecs[k].iv;
            in_data = vecs[k].d; out_ack = vecs[k].ack;
            #1;
            if (!vecs[k].rst && prev_ev) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL %s_sb_empty: got frame with nothing expected", vecs[k].name);
                end else if (vecs[k].ack) begin
                    chk({vecs[k].name, "_frame_ack"}, frame_now(), sb.pop_front());
                end else begin
                    chk({vecs[k].name, "_frame"}, frame_now(), sb[0]);
                end
            end
            if (vecs[k].rst) begin
                sb.delete(); cur = '0; ncur = 0;
            end else if (vecs[k].iv && prev_er) begin
                cur[8*ncur +: 8] = vecs[k].d;
                ncur++;
                if (ncur == 4) begin
                    sb.push_back(cur);
                    cur = '0; ncur = 0;
                end
            end
            @(posedge clk);
            #1;
            chk({vecs[k].name, "_in_ready"}, 32'(in_ready), 32'(vecs[k].er));
            chk({vecs[k].name, "_out_valid"}, 32'(out_valid), 32'(vecs[k].ev));
            chk({vecs[k].name, "_level"}, 32'(level), 32'(vecs[k].el));
            if (k == 0) chk("reset_frame_zero", frame_now(), 32'h0);
            prev_er = vecs[k].er;
            prev_ev = vecs[k].ev;
        end

        @(negedge clk);
        in_valid = 1'b0; out_ack = 1'b0;
        chk("final_sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
